// File: rtl/gtx_align_pkg.sv
// ---------------------------------------------------------------------------
// gtx_align_pkg
// Shared definitions for the GTX comma-alignment monitor.
//   lane_state_e : per-lane alignment state encoding (UNALIGNED=0, LOCKED=1)
//   STATS_W      : width of the optional per-lane loss-of-lock counter
// ---------------------------------------------------------------------------
package gtx_align_pkg;

  typedef enum logic {
    UNALIGNED = 1'b0,
    LOCKED    = 1'b1
  } lane_state_e;

  localparam int STATS_W = 16;

endpackage

// File: rtl/gtx_align_lane.sv
// ---------------------------------------------------------------------------
// gtx_align_lane
// Single-lane acquire/lock/loss state machine for comma-based byte alignment.
// Optional feature macro: ALIGN_STATS_EN (adds a saturating loss counter).
// Ports:
//   clk_i        : clock, rising edge
//   rst_ni       : asynchronous active-low reset
//   comma_i      : comma strobe for this lane
//   code_err_i   : disparity / not-in-table strobe for this lane
//   aligned_o    : lane is LOCKED
//   realign_o    : one-cycle pulse after each LOCKED -> UNALIGNED transition
//   loss_count_o : saturating loss count (ALIGN_STATS_EN only)
// ---------------------------------------------------------------------------
module gtx_align_lane
  import gtx_align_pkg::*;
#(
  parameter int CNT_W          = 5,
  parameter int ACQ_THRESHOLD  = 20,
  parameter int MISS_THRESHOLD = 20,
  parameter int ERR_THRESHOLD  = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               comma_i,
  input  logic               code_err_i,
  output logic               aligned_o,
  output logic               realign_o
`ifdef ALIGN_STATS_EN
  ,
  output logic [STATS_W-1:0] loss_count_o
`endif
);

  localparam logic [CNT_W-1:0] ACQ_LAST  = CNT_W'(ACQ_THRESHOLD - 1);
  localparam logic [CNT_W-1:0] MISS_LAST = CNT_W'(MISS_THRESHOLD - 1);
  localparam logic [CNT_W-1:0] ERR_LAST  = CNT_W'(ERR_THRESHOLD - 1);

  lane_state_e      state_q, state_d;
  logic [CNT_W-1:0] hit_q, hit_d;
  logic [CNT_W-1:0] gap_q, gap_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic             realign_q;
  logic             timeout;
  logic             loss;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= UNALIGNED;
      hit_q     <= '0;
      gap_q     <= '0;
      err_q     <= '0;
      realign_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hit_q     <= hit_d;
      gap_q     <= gap_d;
      err_q     <= err_d;
      realign_q <= loss;
    end
  end

  // A timeout also clears gap_cnt so the counter restarts its window
  // instead of running past the threshold and wrapping.
  always_comb begin
    state_d = state_q;
    hit_d   = hit_q;
    err_d   = err_q;
    loss    = 1'b0;
    timeout = !comma_i && (gap_q == MISS_LAST);
    gap_d   = comma_i ? '0 : gap_q + 1'b1;
    case (state_q)
      UNALIGNED: begin
        if (comma_i) begin
          if (hit_q == ACQ_LAST) begin
            state_d = LOCKED;
            hit_d   = '0;
            gap_d   = '0;
            err_d   = '0;
          end else begin
            hit_d = hit_q + 1'b1;
          end
        end else if (timeout) begin
          hit_d = '0;
          gap_d = '0;
        end
      end
      LOCKED: begin
        // A comma takes priority over a simultaneous code error.
        if (comma_i) begin
          err_d = '0;
        end else if (timeout || (code_err_i && (err_q == ERR_LAST))) begin
          state_d = UNALIGNED;
          hit_d   = '0;
          gap_d   = '0;
          err_d   = '0;
          loss    = 1'b1;
        end else if (code_err_i) begin
          err_d = err_q + 1'b1;
        end
      end
      default: state_d = UNALIGNED;
    endcase
  end

  assign aligned_o = (state_q == LOCKED);
  assign realign_o = realign_q;

`ifdef ALIGN_STATS_EN
  logic [STATS_W-1:0] loss_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      loss_cnt_q <= '0;
    end else if (loss && (loss_cnt_q != '1)) begin
      loss_cnt_q <= loss_cnt_q + 1'b1;
    end
  end

  assign loss_count_o = loss_cnt_q;
`endif

endmodule

// File: rtl/gtx_align_monitor.sv
// ---------------------------------------------------------------------------
// gtx_align_monitor
// Multi-lane comma-based byte-alignment monitor for the EVR GTX receive path.
// Optional feature macro: ALIGN_STATS_EN (exposes loss_count_out).
// Ports:
//   ref_clk           : clock, rising edge
//   rst_n             : asynchronous active-low reset
//   comma_detected    : per-lane comma strobes
//   code_err          : per-lane code-error strobes
//   byteisaligned_out : per-lane lock status
//   all_aligned_out   : registered AND of all lane lock bits
//   realign_out       : per-lane one-cycle loss-of-lock pulse
//   loss_count_out    : per-lane 16-bit loss counts (ALIGN_STATS_EN only)
// ---------------------------------------------------------------------------
module gtx_align_monitor
  import gtx_align_pkg::*;
#(
  parameter int LANES          = 1,
  parameter int CNT_W          = 5,
  parameter int ACQ_THRESHOLD  = 20,
  parameter int MISS_THRESHOLD = 20,
  parameter int ERR_THRESHOLD  = 4
) (
  input  logic                     ref_clk,
  input  logic                     rst_n,
  input  logic [LANES-1:0]         comma_detected,
  input  logic [LANES-1:0]         code_err,
  output logic [LANES-1:0]         byteisaligned_out,
  output logic                     all_aligned_out,
  output logic [LANES-1:0]         realign_out
`ifdef ALIGN_STATS_EN
  ,
  output logic [STATS_W*LANES-1:0] loss_count_out
`endif
);

  logic all_aligned_q;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    gtx_align_lane #(
      .CNT_W         (CNT_W),
      .ACQ_THRESHOLD (ACQ_THRESHOLD),
      .MISS_THRESHOLD(MISS_THRESHOLD),
      .ERR_THRESHOLD (ERR_THRESHOLD)
    ) u_lane (
      .clk_i       (ref_clk),
      .rst_ni      (rst_n),
      .comma_i     (comma_detected[i]),
      .code_err_i  (code_err[i]),
      .aligned_o   (byteisaligned_out[i]),
      .realign_o   (realign_out[i])
`ifdef ALIGN_STATS_EN
      ,
      .loss_count_o(loss_count_out[STATS_W*i +: STATS_W])
`endif
    );
  end

  always_ff @(posedge ref_clk or negedge rst_n) begin
    if (!rst_n) begin
      all_aligned_q <= 1'b0;
    end else begin
      all_aligned_q <= &byteisaligned_out;
    end
  end

  assign all_aligned_out = all_aligned_q;

endmodule

// File: tb/tb_gtx_align_monitor.sv
// ---------------------------------------------------------------------------
// tb_gtx_align_monitor
// Self-checking bench for gtx_align_monitor with LANES=2 and default
// thresholds. A cycle model pushes expected outputs into a scoreboard queue
// as each stimulus cycle is driven; entries are popped after the sampling edge.
// Honours ALIGN_STATS_EN for the loss_count_out port.
// ---------------------------------------------------------------------------
module tb_gtx_align_monitor;

  localparam int LANES = 2;
  localparam int ACQ   = 20;
  localparam int MISS  = 20;
  localparam int ERRT  = 4;

  logic             ref_clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [LANES-1:0] commaDetected = '0;
  logic [LANES-1:0] codeErr = '0;
  logic [LANES-1:0] byteIsAligned;
  logic             allAligned;
  logic [LANES-1:0] realign;
`ifdef ALIGN_STATS_EN
  logic [16*LANES-1:0] lossCount;
`endif

  gtx_align_monitor #(
    .LANES         (LANES),
    .CNT_W         (5),
    .ACQ_THRESHOLD (ACQ),
    .MISS_THRESHOLD(MISS),
    .ERR_THRESHOLD (ERRT)
  ) dut (
    .ref_clk          (ref_clk),
    .rst_n            (rst_n),
    .comma_detected   (commaDetected),
    .code_err         (codeErr),
    .byteisaligned_out(byteIsAligned),
    .all_aligned_out  (allAligned),
    .realign_out      (realign)
`ifdef ALIGN_STATS_EN
    ,
    .loss_count_out   (lossCount)
`endif
  );

  always #5 ref_clk = ~ref_clk;

  typedef struct {
    logic [LANES-1:0] aligned;
    logic             all;
    logic [LANES-1:0] realign;
    logic [31:0]      loss;
  } expect_t;

  expect_t sbQueue[$];
  int checks = 0;
  int errors = 0;

  // Reference model state, one entry per lane
  int mLocked[LANES];
  int mHit[LANES];
  int mGap[LANES];
  int mErr[LANES];
  int mLoss[LANES];

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic resetModel();
    for (int l = 0; l < LANES; l++) begin
      mLocked[l] = 0;
      mHit[l]    = 0;
      mGap[l]    = 0;
      mErr[l]    = 0;
      mLoss[l]   = 0;
    end
    sbQueue.delete();
  endtask

  // Pops one scoreboard entry and compares it against the DUT outputs
  task automatic checkScoreboard();
    expect_t e;
    if (sbQueue.size() == 0) begin
      checkOutput("sbEmpty", 32'd0, 32'd1);
      return;
    end
    e = sbQueue.pop_front();
    checkOutput("sbAligned", 32'(byteIsAligned), 32'(e.aligned));
    checkOutput("sbAll", 32'(allAligned), 32'(e.all));
    checkOutput("sbRealign", 32'(realign), 32'(e.realign));
`ifdef ALIGN_STATS_EN
    checkOutput("sbLoss", lossCount, e.loss);
`endif
  endtask

  // Drives one cycle of stimulus, predicts the post-edge outputs, then
  // samples 1 time unit after the rising edge.
  task automatic applyStimulus(input logic [LANES-1:0] comma, input logic [LANES-1:0] err);
    expect_t e;
    logic    prevAnd;
    int      tmo;
    commaDetected = comma;
    codeErr       = err;
    prevAnd = 1'b1;
    for (int l = 0; l < LANES; l++) prevAnd &= (mLocked[l] != 0);
    e.realign = '0;
    for (int l = 0; l < LANES; l++) begin
      tmo = (!comma[l] && mGap[l] == MISS - 1) ? 1 : 0;
      if (mLocked[l] == 0) begin
        if (comma[l]) begin
          mGap[l] = 0;
          if (mHit[l] == ACQ - 1) begin
            mLocked[l] = 1;
            mHit[l]    = 0;
            mErr[l]    = 0;
          end else begin
            mHit[l]++;
          end
        end else if (tmo != 0) begin
          mHit[l] = 0;
          mGap[l] = 0;
        end else begin
          mGap[l]++;
        end
      end else begin
        if (comma[l]) begin
          mErr[l] = 0;
          mGap[l] = 0;
        end else if (tmo != 0 || (err[l] && mErr[l] == ERRT - 1)) begin
          mLocked[l]   = 0;
          mHit[l]      = 0;
          mGap[l]      = 0;
          mErr[l]      = 0;
          e.realign[l] = 1'b1;
          if (mLoss[l] < 65535) mLoss[l]++;
        end else begin
          mGap[l]++;
          if (err[l]) mErr[l]++;
        end
      end
    end
    for (int l = 0; l < LANES; l++) e.aligned[l] = (mLocked[l] != 0);
    e.all  = prevAnd;
    e.loss = {16'(mLoss[1]), 16'(mLoss[0])};
    sbQueue.push_back(e);
    @(posedge ref_clk);
    #1;
    checkScoreboard();
  endtask

  initial begin
    resetModel();
    #2;
    checkOutput("rstAligned", 32'(byteIsAligned), 32'd0);
    checkOutput("rstAll", 32'(allAligned), 32'd0);
    checkOutput("rstRealign", 32'(realign), 32'd0);
    #1;
    rst_n = 1'b1;

    // Acquisition on both lanes with continuous commas
    for (int i = 0; i < ACQ - 1; i++) applyStimulus(2'b11, 2'b00);
    checkOutput("lockEarly", 32'(byteIsAligned), 32'd0);
    applyStimulus(2'b11, 2'b00);
    checkOutput("lockEdge", 32'(byteIsAligned), 32'd3);
    checkOutput("lockAllLag", 32'(allAligned), 32'd0);
    applyStimulus(2'b11, 2'b00);
    checkOutput("lockAll", 32'(allAligned), 32'd1);

    // Lane 0 timeout while lane 1 keeps receiving commas
    for (int i = 0; i < MISS; i++) applyStimulus(2'b10, 2'b00);
    checkOutput("tmoAligned", 32'(byteIsAligned), 32'd2);
    checkOutput("tmoRealign", 32'(realign), 32'd1);
    applyStimulus(2'b11, 2'b00);
    checkOutput("tmoPulseEnd", 32'(realign), 32'd0);
    checkOutput("tmoAllFall", 32'(allAligned), 32'd0);

    // Re-lock lane 0, then near-miss gaps that must never time out
    for (int i = 0; i < ACQ; i++) applyStimulus(2'b11, 2'b00);
    for (int r = 0; r < 100; r++) begin
      for (int i = 0; i < MISS - 1; i++) applyStimulus(2'b10, 2'b00);
      applyStimulus(2'b11, 2'b00);
    end
    checkOutput("gapHold", 32'(byteIsAligned), 32'd3);

    // Error threshold: a comma with a simultaneous error resets the count
    for (int i = 0; i < 3; i++) applyStimulus(2'b10, 2'b01);
    applyStimulus(2'b11, 2'b01);
    for (int i = 0; i < 3; i++) applyStimulus(2'b10, 2'b01);
    checkOutput("errHold", 32'(byteIsAligned), 32'd3);
    applyStimulus(2'b10, 2'b01);
    checkOutput("errDrop", 32'(byteIsAligned), 32'd2);
    checkOutput("errRealign", 32'(realign), 32'd1);

    // Acquisition interrupted by a timeout restarts the comma count
    for (int i = 0; i < 10; i++) applyStimulus(2'b11, 2'b00);
    for (int i = 0; i < MISS; i++) applyStimulus(2'b10, 2'b00);
    for (int i = 0; i < ACQ - 1; i++) applyStimulus(2'b11, 2'b00);
    checkOutput("reacqEarly", 32'(byteIsAligned), 32'd2);
    applyStimulus(2'b11, 2'b00);
    checkOutput("reacqLock", 32'(byteIsAligned), 32'd3);

    // Three losses on lane 1
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < MISS; i++) applyStimulus(2'b01, 2'b00);
      if (r < 2) for (int i = 0; i < ACQ; i++) applyStimulus(2'b11, 2'b00);
    end
    checkOutput("lane1Lost", 32'(byteIsAligned), 32'd1);
`ifdef ALIGN_STATS_EN
    checkOutput("lossLane1", 32'(lossCount[31:16]), 32'd3);
    checkOutput("lossLane0", 32'(lossCount[15:0]), 32'd2);
`endif

    // Asynchronous reset in the middle of acquisition
    for (int i = 0; i < 5; i++) applyStimulus(2'b11, 2'b00);
    rst_n = 1'b0;
    #1;
    checkOutput("midRstAligned", 32'(byteIsAligned), 32'd0);
    checkOutput("midRstAll", 32'(allAligned), 32'd0);
    checkOutput("midRstRealign", 32'(realign), 32'd0);
`ifdef ALIGN_STATS_EN
    checkOutput("midRstLoss", lossCount, 32'd0);
`endif
    resetModel();
    #3;
    rst_n = 1'b1;
    for (int i = 0; i < ACQ + 1; i++) applyStimulus(2'b11, 2'b00);
    checkOutput("postRstLock", 32'(byteIsAligned), 32'd3);
    checkOutput("postRstAll", 32'(allAligned), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gtx_align_monitor.md
# gtx_align_monitor

Multi-lane comma-based byte-alignment monitor for the GTX receive path of the EVR. Each lane runs an acquire/lock/loss state machine with independent acquisition, comma-gap and code-error thresholds. It reports per-lane and aggregate alignment status and emits a one-cycle realign request on every loss of lock. It sits between the GTX comma/decoder status outputs and the EVR link-up logic.

## Interface
- LANES, 1, number of independent receive lanes monitored.
- CNT_W, 5, width of every internal counter; must satisfy 2^CNT_W > max(ACQ_THRESHOLD, MISS_THRESHOLD, ERR_THRESHOLD).
- ACQ_THRESHOLD, 20, commas needed to declare alignment; ≥1.
- MISS_THRESHOLD, 20, consecutive comma-less cycles that cause a timeout; ≥1.
- ERR_THRESHOLD, 4, code errors between two commas that cause loss of lock; ≥1.
- ref_clk  in  1  recovered/reference clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- comma_detected  in  LANES  per-lane comma strobe, sampled every cycle.
- code_err  in  LANES  per-lane disparity or not-in-table strobe.
- byteisaligned_out  out  LANES  per-lane lock status.
- all_aligned_out  out  1  registered AND of all lane lock bits.
- realign_out  out  LANES  one-cycle pulse on each lane's transition from LOCKED to UNALIGNED.
- loss_count_out  out  16*LANES  per-lane saturating loss-of-lock count; present only with ALIGN_STATS_EN.

## Operation
- Per-lane states: UNALIGNED, LOCKED. Each lane keeps hit_cnt, gap_cnt and err_cnt, all CNT_W bits wide.
- Every cycle, per lane: a comma clears gap_cnt. A cycle without a comma increments gap_cnt. A timeout occurs when a comma is absent and gap_cnt == MISS_THRESHOLD-1.
- UNALIGNED:
  - A comma increments hit_cnt.
  - A comma arriving while hit_cnt == ACQ_THRESHOLD-1 moves the lane to LOCKED and clears all counters.
  - A timeout clears hit_cnt; the lane stays UNALIGNED.
  - code_err is ignored.
- LOCKED:
  - A comma clears err_cnt.
  - code_err without a comma increments err_cnt.
  - Loss of lock occurs on a timeout, or on code_err without a comma while err_cnt == ERR_THRESHOLD-1.
  - On loss: go to UNALIGNED, clear all counters, pulse realign_out for one cycle.
- Simultaneous comma and code_err on a lane: the comma wins; err_cnt clears and the error is not counted.
- Counters never wrap; the thresholds bound them.
- Lanes are fully independent. all_aligned_out = AND of byteisaligned_out, registered.

## Timing
- Reset values: all lanes UNALIGNED, all counters 0, byteisaligned_out=0, all_aligned_out=0, realign_out=0, loss_count_out=0.
- Lock latency: byteisaligned_out rises on the edge that samples the ACQ_THRESHOLD-th comma.
- Aggregate latency: all_aligned_out follows the per-lane bits one cycle later.
- Timeout latency: byteisaligned_out falls on the edge that samples the MISS_THRESHOLD-th consecutive comma-less cycle. realign_out is high during the cycle after that edge.
- Reset mid-operation: every output returns to its reset value asynchronously. The first edge after reset deassertion is treated as a normal sampling cycle.

## Configuration
- ALIGN_STATS_EN defined:
  - Each lane keeps a 16-bit loss counter, incremented on every realign pulse and saturating at 0xFFFF.
  - The count is visible on loss_count_out; the lane's count sits in bits [16*i +: 16].
- ALIGN_STATS_EN undefined:
  - The port and the counters are absent.
  - All other behaviour is identical.

## Structure
- Package gtx_align_pkg: lane state encoding (UNALIGNED=0, LOCKED=1) and the stats counter width constant (16).
- Sub-module gtx_align_lane: the single-lane FSM and its counters, instantiated LANES times in a generate loop.
- Top level holds only the aggregate AND register and the port packing.

## Test plan
- Reset, then assert comma on every cycle with LANES=2, ACQ_THRESHOLD=20: byteisaligned_out=2'b11 on the 20th sampling edge; all_aligned_out one edge later; realign_out stays 0.
- Locked lane 0, then 20 comma-less cycles: lane 0 drops on the 20th edge; realign_out[0] pulses one cycle; lane 1 unaffected; all_aligned_out falls the next edge.
- Locked lane, then 19 comma-less cycles, then a comma: lane stays locked and gap_cnt clears; repeat 100 times with no realign.
- Locked lane, ERR_THRESHOLD=4: 3 code_err, then a comma with code_err together, then 3 code_err: lane stays locked. One more code_err without a comma: lane drops and realign pulses.
- UNALIGNED lane: 10 commas, 20 idle cycles, 19 commas: no lock; the 20th comma locks.
- With ALIGN_STATS_EN: force 3 losses on lane 1 → loss_count_out[31:16]=3. Assert rst_n=0 mid-acquisition: all outputs read 0 immediately.
